// File: rtl/enc_event_queue.sv
// Synchronous FWFT FIFO buffering 2-bit priority-encoder codes behind a valid/ready port.
// Optional macro ENC_QUEUE_DEDUP_EN suppresses repeated pushes of a held code.
module enc_event_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_code,
  input  logic             in_valid,
  output logic [1:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             push_req;
  logic             push;
  logic             pop;

`ifdef ENC_QUEUE_DEDUP_EN
  logic       prev_valid;
  logic [1:0] prev_code;

  // History tracks the raw input every cycle, even when the push itself is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
      prev_code  <= '0;
    end else begin
      prev_valid <= in_valid;
      prev_code  <= in_code;
    end
  end

  assign push_req = in_valid && !(prev_valid && (in_code == prev_code));
`else
  assign push_req = in_valid;
`endif

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign out_valid = !empty;
  assign out_code  = empty ? 2'b00 : mem[rp];

  assign pop  = out_valid && out_ready;
  assign push = push_req && (!full || pop);

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wp] <= in_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W + 1)'(1);
      end
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
